// File: rtl/tiny_dnn_pkg.sv
// Shared types and sizing for the tiny_dnn layer sequencer.
package tiny_dnn_pkg;

    localparam int F_NUM   = 16;
    localparam int F_SIZE  = 512;
    localparam int AW      = 13;
    localparam int FMA_LAT = 2;

    localparam int CW = $clog2(F_NUM);
    localparam int IW = $clog2(F_SIZE);
    localparam int LW = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_EXEC,
        S_DRAIN,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_OUT
    } seq_state_t;

endpackage

// File: rtl/tiny_dnn_seq.sv
// Layer sequencer for tiny_dnn_top: weight load, init, exec stream, drain, readout.
// Exec 1 beat/cycle under src_valid; readout 1 result per 3 cycles, held until dst_ready.
import tiny_dnn_pkg::*;

module tiny_dnn_seq (
    input  logic              clk,
    input  logic              reset,
    input  logic              wl_valid,
    output logic              wl_ready,
    input  logic [AW-1:0]     wl_addr,
    input  logic [31:0]       wl_data,
    input  logic              start,
    input  logic [LW-1:0]     in_len,
    output logic              busy,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [31:0]       src_data,
    output logic              dst_valid,
    input  logic              dst_ready,
    output logic [31:0]       dst_data,
    output logic              dst_last,
    output logic              dnn_write,
    output logic              dnn_init,
    output logic              dnn_exec,
    output logic [AW-1:0]     dnn_a,
    output logic [31:0]       dnn_d,
    input  logic [31:0]       dnn_x
);

    seq_state_t      state_q, state_d;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   idx_q;
    logic [CW-1:0]   rn_q;
    logic [1:0]      drain_q;
    logic [31:0]     dst_data_q;

    logic [AW-1:0]   idx_addr;
    logic [AW-1:0]   rn_addr;

    assign idx_addr = AW'(idx_q[IW-1:0]);
    assign rn_addr  = AW'(rn_q);
    assign dst_data = dst_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are gated by reset so a mid-run abort shows all-zero controls at once.
    always_comb begin
        state_d   = state_q;
        wl_ready  = 1'b0;
        src_ready = 1'b0;
        dst_valid = 1'b0;
        dst_last  = 1'b0;
        busy      = 1'b0;
        dnn_write = 1'b0;
        dnn_init  = 1'b0;
        dnn_exec  = 1'b0;
        dnn_a     = '0;
        dnn_d     = '0;
        if (!reset) begin
            busy = (state_q != S_IDLE);
            unique case (state_q)
                S_IDLE: begin
                    wl_ready = !start;
                    if (start) begin
                        state_d = S_INIT;
                    end else if (wl_valid) begin
                        dnn_write = 1'b1;
                        dnn_a     = wl_addr;
                        dnn_d     = wl_data;
                    end
                end
                S_INIT: begin
                    dnn_init = 1'b1;
                    state_d  = (len_q == '0) ? S_DRAIN : S_EXEC;
                end
                S_EXEC: begin
                    src_ready = 1'b1;
                    dnn_a     = idx_addr;
                    if (src_valid) begin
                        dnn_exec = 1'b1;
                        dnn_d    = src_data;
                        if (idx_q == len_q - LW'(1)) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == 2'(FMA_LAT - 1)) begin
                        state_d = S_RD_ADDR;
                    end
                end
                // top re-registers x whenever controls are low, so a holds rn through readout
                S_RD_ADDR: begin
                    dnn_a   = rn_addr;
                    state_d = S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    dnn_a   = rn_addr;
                    state_d = S_RD_OUT;
                end
                S_RD_OUT: begin
                    dnn_a     = rn_addr;
                    dst_valid = 1'b1;
                    dst_last  = (rn_q == CW'(F_NUM - 1));
                    if (dst_ready) begin
                        state_d = (rn_q == CW'(F_NUM - 1)) ? S_IDLE : S_RD_ADDR;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q      <= '0;
            idx_q      <= '0;
            rn_q       <= '0;
            drain_q    <= '0;
            dst_data_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q <= (in_len > LW'(F_SIZE)) ? LW'(F_SIZE) : in_len;
                        idx_q <= '0;
                    end
                end
                S_INIT: begin
                    drain_q <= '0;
                end
                S_EXEC: begin
                    drain_q <= '0;
                    if (src_valid) begin
                        idx_q <= idx_q + LW'(1);
                    end
                end
                S_DRAIN: begin
                    drain_q <= drain_q + 2'd1;
                    rn_q    <= '0;
                end
                S_RD_WAIT: begin
                    dst_data_q <= dnn_x;
                end
                S_RD_OUT: begin
                    if (dst_ready) begin
                        rn_q <= rn_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
